// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the CPU memory arbiter
package mem_arb_pkg;

    localparam int MEM_LAT_DEF    = 2;
    localparam int STARVE_MAX_DEF = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
        logic   killed;
    } tag_t;

    // A taken jump makes every fetch still travelling through the memory wrong-path.
    function automatic tag_t killFetch(input tag_t t, input logic flush);
        tag_t r;
        r = t;
        if (flush && t.owner == OWN_IF)
            r.killed = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// rtl/mem_arb_tag_pipe.sv - MEM_LAT-deep response tag pipe with flush kill
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t push,
    input  logic flush,
    output tag_t head
);

    tag_t pipe [MEM_LAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= push;
            for (int i = 1; i < MEM_LAT; i++)
                pipe[i] <= killFetch(pipe[i-1], flush);
        end
    end

    // The entry leaving this cycle is also wrong-path if the jump resolves now.
    assign head = killFetch(pipe[MEM_LAT-1], flush);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one pipelined memory; MEM_ARBITER_STATS_EN adds grant counters
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MEM_LAT    = MEM_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              flush,
    input  logic              halt,
    output logic              m_en,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    output logic [15:0]       stat_if,
    output logic [15:0]       stat_d,
    output logic [15:0]       stat_starve
);

    localparam int                CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_TOP = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starveCnt;
    logic             halted;
    logic             grantOk;
    logic             starveHit;
    logic             starveOverride;
    logic             ifGnt;
    logic             dGnt;
    tag_t             pushTag;
    tag_t             headTag;

    // The halt cycle itself already issues nothing; the latch keeps it that way.
    always_comb begin
        grantOk        = !(halted || halt);
        starveHit      = (starveCnt == STARVE_TOP);
        ifGnt          = grantOk && if_req && (!d_req || starveHit);
        dGnt           = grantOk && d_req && !(if_req && starveHit);
        starveOverride = grantOk && if_req && d_req && starveHit;
    end

    always_comb begin
        m_en    = ifGnt || dGnt;
        m_we    = dGnt && d_we;
        m_addr  = '0;
        m_wdata = '0;
        if (ifGnt) begin
            m_addr = if_addr;
        end else if (dGnt) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            halted <= 1'b0;
        else if (halt)
            halted <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starveCnt <= '0;
        else if (!if_req || ifGnt)
            starveCnt <= '0;
        else if (!starveHit)
            starveCnt <= starveCnt + 1'b1;
    end

    // Stores complete at issue, so only reads occupy a tag slot.
    always_comb begin
        pushTag        = '0;
        pushTag.valid  = ifGnt || (dGnt && !d_we);
        pushTag.owner  = ifGnt ? OWN_IF : OWN_D;
        pushTag.killed = 1'b0;
    end

    mem_arb_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (pushTag),
        .flush (flush),
        .head  (headTag)
    );

    always_comb begin
        if_gnt    = ifGnt;
        d_gnt     = dGnt;
        if_rvalid = headTag.valid && !headTag.killed && headTag.owner == OWN_IF;
        d_rvalid  = headTag.valid && headTag.owner == OWN_D;
        if_rdata  = if_rvalid ? m_rdata : '0;
        d_rdata   = d_rvalid ? m_rdata : '0;
    end

`ifdef MEM_ARBITER_STATS_EN
    logic [15:0] statIf;
    logic [15:0] statD;
    logic [15:0] statStarve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            statIf     <= '0;
            statD      <= '0;
            statStarve <= '0;
        end else begin
            if (ifGnt && statIf != 16'hFFFF)
                statIf <= statIf + 16'd1;
            if (dGnt && statD != 16'hFFFF)
                statD <= statD + 16'd1;
            if (starveOverride && statStarve != 16'hFFFF)
                statStarve <= statStarve + 16'd1;
        end
    end

    assign stat_if     = statIf;
    assign stat_d      = statD;
    assign stat_starve = statStarve;
`else
    assign stat_if     = '0;
    assign stat_d      = '0;
    assign stat_starve = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [15:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [15:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        flush;
    logic        halt;
    logic        m_en;
    logic        m_we;
    logic [15:0] m_addr;
    logic [15:0] m_wdata;
    logic [15:0] m_rdata;
    logic [15:0] stat_if;
    logic [15:0] stat_d;
    logic [15:0] stat_starve;

    int nVec = 0;
    int nMis = 0;

    mem_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_gnt      (if_gnt),
        .if_rvalid   (if_rvalid),
        .if_rdata    (if_rdata),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_gnt       (d_gnt),
        .d_rvalid    (d_rvalid),
        .d_rdata     (d_rdata),
        .flush       (flush),
        .halt        (halt),
        .m_en        (m_en),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .stat_if     (stat_if),
        .stat_d      (stat_d),
        .stat_starve (stat_starve)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns addr+0x100, two cycles after the access.
    logic [15:0] rd0;
    logic [15:0] rd1;
    always @(posedge clk) begin
        rd0 <= m_en ? (m_addr + 16'h0100) : 16'h0000;
        rd1 <= rd0;
    end
    assign m_rdata = rd1;

    task automatic checkVec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_req  = 1'b0;
        if_addr = 16'h0000;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0000;
        d_wdata = 16'h0000;
        flush   = 1'b0;
        halt    = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkVec("rst_if_gnt", 32'(if_gnt), 32'd0);
        checkVec("rst_d_gnt", 32'(d_gnt), 32'd0);
        checkVec("rst_m_en", 32'(m_en), 32'd0);
        checkVec("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        checkVec("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        nextCycle();
        rst_n = 1'b1;
        nextCycle();

        // fetch stream 0..3
        for (int c = 0; c < 7; c++) begin
            if_req  = (c < 4);
            if_addr = 16'(c);
            @(negedge clk);
            if (c < 4) begin
                checkVec("t1_if_gnt", 32'(if_gnt), 32'd1);
                checkVec("t1_m_addr", 32'(m_addr), 32'(c));
            end
            checkVec("t1_if_rvalid", 32'(if_rvalid), 32'(c >= 2 && c < 6));
            checkVec("t1_if_rdata", 32'(if_rdata), (c >= 2 && c < 6) ? 32'(16'h0100 + c - 2) : 32'd0);
            nextCycle();
        end
        idle();

        // both ports requesting for 8 cycles, fetch wins only on the fifth
        for (int c = 0; c < 10; c++) begin
            if_req  = (c < 8);
            d_req   = (c < 8);
            d_we    = 1'b0;
            if_addr = 16'h0010;
            d_addr  = 16'h0040;
            @(negedge clk);
            if (c < 8) begin
                checkVec("t2_if_gnt", 32'(if_gnt), 32'(c == 4));
                checkVec("t2_d_gnt", 32'(d_gnt), 32'(c != 4));
                checkVec("t2_m_addr", 32'(m_addr), (c == 4) ? 32'h10 : 32'h40);
            end
            checkVec("t2_if_rvalid", 32'(if_rvalid), 32'(c == 6));
            checkVec("t2_d_rvalid", 32'(d_rvalid), 32'(c >= 2 && c != 6));
            if (c == 6)
                checkVec("t2_if_rdata", 32'(if_rdata), 32'h0110);
            else if (c >= 2)
                checkVec("t2_d_rdata", 32'(d_rdata), 32'h0140);
            nextCycle();
        end
        idle();

        // store: issued, no response
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0050;
        d_wdata = 16'hBEEF;
        @(negedge clk);
        checkVec("t3_d_gnt", 32'(d_gnt), 32'd1);
        checkVec("t3_m_en", 32'(m_en), 32'd1);
        checkVec("t3_m_we", 32'(m_we), 32'd1);
        checkVec("t3_m_addr", 32'(m_addr), 32'h0050);
        checkVec("t3_m_wdata", 32'(m_wdata), 32'hBEEF);
        nextCycle();
        idle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkVec("t3_d_rvalid", 32'(d_rvalid), 32'd0);
            nextCycle();
        end

        // flush kills 0x20/0x21, redirect 0x30 survives
        for (int c = 0; c < 6; c++) begin
            if_req  = (c < 3);
            if_addr = (c == 0) ? 16'h0020 : (c == 1) ? 16'h0021 : 16'h0030;
            flush   = (c == 2);
            @(negedge clk);
            if (c < 3)
                checkVec("t4_if_gnt", 32'(if_gnt), 32'd1);
            checkVec("t4_if_rvalid", 32'(if_rvalid), 32'(c == 4));
            checkVec("t4_if_rdata", 32'(if_rdata), (c == 4) ? 32'h0130 : 32'd0);
            nextCycle();
        end
        idle();

        // halt with a load in flight
        d_req  = 1'b1;
        d_addr = 16'h0060;
        @(negedge clk);
        checkVec("t5_d_gnt", 32'(d_gnt), 32'd1);
        nextCycle();
        d_req   = 1'b0;
        if_req  = 1'b1;
        if_addr = 16'h0080;
        halt    = 1'b1;
        nextCycle();
        halt = 1'b0;
        @(negedge clk);
        checkVec("t5_d_rvalid", 32'(d_rvalid), 32'd1);
        checkVec("t5_d_rdata", 32'(d_rdata), 32'h0160);
        checkVec("t5_if_gnt", 32'(if_gnt), 32'd0);
        nextCycle();
        d_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkVec("t5_if_gnt_halted", 32'(if_gnt), 32'd0);
            checkVec("t5_d_gnt_halted", 32'(d_gnt), 32'd0);
            checkVec("t5_m_en_halted", 32'(m_en), 32'd0);
            nextCycle();
        end
        d_req = 1'b0;
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        @(negedge clk);
        checkVec("t5_if_gnt_after_rst", 32'(if_gnt), 32'd1);
        nextCycle();
        idle();
        for (int c = 0; c < 3; c++)
            nextCycle();

        // reset right after a load grant discards its response
        d_req  = 1'b1;
        d_addr = 16'h0070;
        @(negedge clk);
        checkVec("t6_d_gnt", 32'(d_gnt), 32'd1);
        nextCycle();
        idle();
        rst_n = 1'b0;
        nextCycle();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkVec("t6_d_rvalid", 32'(d_rvalid), 32'd0);
            checkVec("t6_if_rvalid", 32'(if_rvalid), 32'd0);
            nextCycle();
        end
        checkVec("t6_stat_d_rst", 32'(stat_d), 32'd0);
        checkVec("t6_stat_if_rst", 32'(stat_if), 32'd0);
        d_req = 1'b1;
        for (int c = 0; c < 3; c++) begin
            d_addr = 16'(c);
            nextCycle();
        end
        idle();
        @(negedge clk);
`ifdef MEM_ARBITER_STATS_EN
        checkVec("t6_stat_d", 32'(stat_d), 32'd3);
`else
        checkVec("t6_stat_d", 32'(stat_d), 32'd0);
`endif
        checkVec("t6_stat_if", 32'(stat_if), 32'd0);
        checkVec("t6_stat_starve", 32'(stat_starve), 32'd0);
        nextCycle();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
